// File: rtl/nfc_command_arbiter_if.sv
// Bus bundle between the command sequencers and the command arbiter.
// The arbiter takes the slave view. The sequencer side (or a testbench) takes the master view.
interface nfc_command_arbiter_if #(
    parameter int NumberOfWays    = 4,
    parameter int NumOfCmdModules = 4
);
    // Host / sequencer handshake
    logic                                    iCMDValid;
    logic [NumOfCmdModules-1:0]              iCMDReady;
    logic                                    oCMDReady;
    logic [NumOfCmdModules-1:0]              iCMD_Start;
    logic [NumOfCmdModules-1:0]              iCMD_LastStep;

    // Packed per-sequencer ACG request fields
    logic [8*NumOfCmdModules-1:0]            iCMD_ACG_Command;
    logic [3*NumOfCmdModules-1:0]            iCMD_ACG_CommandOption;
    logic [NumberOfWays*NumOfCmdModules-1:0] iCMD_ACG_TargetWay;
    logic [16*NumOfCmdModules-1:0]           iCMD_ACG_NumOfData;
    logic [NumOfCmdModules-1:0]              iCMD_ACG_CASelect;
    logic [40*NumOfCmdModules-1:0]           iCMD_ACG_CAData;

    // Forwarded ACG request from the current owner
    logic [7:0]                              oACG_Command;
    logic [2:0]                              oACG_CommandOption;
    logic [NumberOfWays-1:0]                 oACG_TargetWay;
    logic [15:0]                             oACG_NumOfData;
    logic                                    oACG_CASelect;
    logic [39:0]                             oACG_CAData;

    // Arbiter status
    logic [NumOfCmdModules-1:0]              oGrant;
    logic                                    oBusy;
    logic                                    oLastStep;
    logic                                    oTimeout;
    logic                                    oCollision;

    modport slave (
        input  iCMDValid, iCMDReady, iCMD_Start, iCMD_LastStep,
        input  iCMD_ACG_Command, iCMD_ACG_CommandOption, iCMD_ACG_TargetWay,
        input  iCMD_ACG_NumOfData, iCMD_ACG_CASelect, iCMD_ACG_CAData,
        output oCMDReady,
        output oACG_Command, oACG_CommandOption, oACG_TargetWay,
        output oACG_NumOfData, oACG_CASelect, oACG_CAData,
        output oGrant, oBusy, oLastStep, oTimeout, oCollision
    );

    modport master (
        output iCMDValid, iCMDReady, iCMD_Start, iCMD_LastStep,
        output iCMD_ACG_Command, iCMD_ACG_CommandOption, iCMD_ACG_TargetWay,
        output iCMD_ACG_NumOfData, iCMD_ACG_CASelect, iCMD_ACG_CAData,
        input  oCMDReady,
        input  oACG_Command, oACG_CommandOption, oACG_TargetWay,
        input  oACG_NumOfData, oACG_CASelect, oACG_CAData,
        input  oGrant, oBusy, oLastStep, oTimeout, oCollision
    );
endinterface

// File: rtl/nfc_command_arbiter.sv
// Round-robin arbiter that shares the single ACG request bus among the
// command sequencers. It grants one owner per command, forwards the owner's
// request through a registered mux, gates host acceptance while busy and
// runs a per-grant watchdog.
module nfc_command_arbiter #(
    parameter int          NumberOfWays    = 4,
    parameter int          NumOfCmdModules = 4,
    parameter logic [31:0] TimeoutCycles   = 32'd1000000
) (
    input  logic                       iSystemClock,
    input  logic                       iReset,
    nfc_command_arbiter_if.slave       bus
);
    localparam int N      = NumOfCmdModules;
    localparam int IdxW   = (N > 1) ? $clog2(N) : 1;
    localparam int WayW   = NumberOfWays;

    typedef logic [IdxW-1:0] idx_t;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Unpacked per-sequencer request fields
    logic [7:0]      cmd_arr  [N];
    logic [2:0]      opt_arr  [N];
    logic [WayW-1:0] way_arr  [N];
    logic [15:0]     num_arr  [N];
    logic            casel_arr[N];
    logic [39:0]     cad_arr  [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign cmd_arr[gi]   = bus.iCMD_ACG_Command[gi*8 +: 8];
            assign opt_arr[gi]   = bus.iCMD_ACG_CommandOption[gi*3 +: 3];
            assign way_arr[gi]   = bus.iCMD_ACG_TargetWay[gi*WayW +: WayW];
            assign num_arr[gi]   = bus.iCMD_ACG_NumOfData[gi*16 +: 16];
            assign casel_arr[gi] = bus.iCMD_ACG_CASelect[gi];
            assign cad_arr[gi]   = bus.iCMD_ACG_CAData[gi*40 +: 40];
        end
    endgenerate

    // Registered state and outputs
    state_t          state_reg;
    idx_t            owner_reg;
    idx_t            rr_ptr_reg;
    logic [31:0]     counter_reg;
    logic [N-1:0]    grant_reg;
    logic            busy_reg;
    logic            last_step_reg;
    logic            timeout_reg;
    logic            collision_reg;
    logic            ready_en_reg;
    logic [7:0]      acg_cmd_reg;
    logic [2:0]      acg_opt_reg;
    logic [WayW-1:0] acg_way_reg;
    logic [15:0]     acg_num_reg;
    logic            acg_casel_reg;
    logic [39:0]     acg_cad_reg;

    // Round-robin pick
    logic            pick_valid;
    idx_t            pick_idx;
    int              pick_scan;

    // Host command valid is observed only; it does not influence arbitration
    wire unused_cmd_valid = bus.iCMDValid;

    // Round-robin search: scan offsets from the highest down so the lowest
    // offset from the pointer is the last (winning) assignment
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_scan  = 0;
        for (int off = N - 1; off >= 0; off--) begin
            pick_scan = (int'(rr_ptr_reg) + off) % N;
            if (bus.iCMD_Start[pick_scan]) begin
                pick_valid = 1'b1;
                pick_idx   = idx_t'(pick_scan);
            end
        end
    end

    logic owner_last;
    logic owner_expire;
    logic foreign_start;
    idx_t next_ptr;

    assign owner_last    = bus.iCMD_LastStep[owner_reg];
    assign owner_expire  = (TimeoutCycles != 32'd0) &&
                           (counter_reg == (TimeoutCycles - 32'd1));
    assign foreign_start = |(bus.iCMD_Start & ~grant_reg);
    assign next_ptr      = (owner_reg == idx_t'(N - 1)) ? '0 : owner_reg + idx_t'(1);

    // Arbiter FSM with registered grant, status pulses and ACG mux
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            counter_reg   <= '0;
            grant_reg     <= '0;
            busy_reg      <= 1'b0;
            last_step_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            collision_reg <= 1'b0;
            ready_en_reg  <= 1'b0;
            acg_cmd_reg   <= '0;
            acg_opt_reg   <= '0;
            acg_way_reg   <= '0;
            acg_num_reg   <= '0;
            acg_casel_reg <= 1'b1;
            acg_cad_reg   <= '0;
        end else begin
            ready_en_reg  <= 1'b1;
            last_step_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            collision_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_reg     <= ST_GRANT;
                        owner_reg     <= pick_idx;
                        grant_reg     <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        busy_reg      <= 1'b1;
                        counter_reg   <= '0;
                        acg_cmd_reg   <= cmd_arr[pick_idx];
                        acg_opt_reg   <= opt_arr[pick_idx];
                        acg_way_reg   <= way_arr[pick_idx];
                        acg_num_reg   <= num_arr[pick_idx];
                        acg_casel_reg <= casel_arr[pick_idx];
                        acg_cad_reg   <= cad_arr[pick_idx];
                    end
                end
                ST_GRANT: begin
                    if (counter_reg != 32'hFFFF_FFFF) begin
                        counter_reg <= counter_reg + 32'd1;
                    end
                    // Starts from other sequencers are flagged but never queued
                    if (foreign_start) begin
                        collision_reg <= 1'b1;
                    end
                    if (owner_last || owner_expire) begin
                        // Last step takes priority over a coinciding expiry
                        last_step_reg <= owner_last;
                        timeout_reg   <= ~owner_last;
                        state_reg     <= ST_RELEASE;
                        grant_reg     <= '0;
                        acg_cmd_reg   <= '0;
                        acg_opt_reg   <= '0;
                        acg_way_reg   <= '0;
                        acg_num_reg   <= '0;
                        acg_casel_reg <= 1'b1;
                        acg_cad_reg   <= '0;
                    end else begin
                        acg_cmd_reg   <= cmd_arr[owner_reg];
                        acg_opt_reg   <= opt_arr[owner_reg];
                        acg_way_reg   <= way_arr[owner_reg];
                        acg_num_reg   <= num_arr[owner_reg];
                        acg_casel_reg <= casel_arr[owner_reg];
                        acg_cad_reg   <= cad_arr[owner_reg];
                    end
                end
                ST_RELEASE: begin
                    // One dead cycle; fairness pointer moves past the old owner
                    state_reg  <= ST_IDLE;
                    busy_reg   <= 1'b0;
                    rr_ptr_reg <= next_ptr;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Host may issue only when every sequencer is ready and no grant is live
    assign bus.oCMDReady = (&bus.iCMDReady) & (state_reg == ST_IDLE) & ready_en_reg;

    assign bus.oACG_Command       = acg_cmd_reg;
    assign bus.oACG_CommandOption = acg_opt_reg;
    assign bus.oACG_TargetWay     = acg_way_reg;
    assign bus.oACG_NumOfData     = acg_num_reg;
    assign bus.oACG_CASelect      = acg_casel_reg;
    assign bus.oACG_CAData        = acg_cad_reg;
    assign bus.oGrant             = grant_reg;
    assign bus.oBusy              = busy_reg;
    assign bus.oLastStep          = last_step_reg;
    assign bus.oTimeout           = timeout_reg;
    assign bus.oCollision         = collision_reg;

endmodule

// File: doc/nfc_command_arbiter.md
Name: nfc_command_arbiter

Overview:
- Shares the single atomic command generator (ACG) request bus among NumOfCmdModules command sequencers (get/set feature, reset, read ID, page program/read, ...).
- Watches each sequencer's start and last-step strobes, grants one owner at a time with round-robin fairness, and forwards the owner's ACG request fields through a registered mux.
- Gates host command acceptance while busy and runs a per-command watchdog.
- Sits between the command sequencers and the ACG.

Parameters:
NumberOfWays, 4, width of the way-select / target-way vectors
NumOfCmdModules, 4, number of command sequencers arbitrated (N, ≥2)
TimeoutCycles, 32'd1000000, watchdog limit in clocks per grant; 0 disables the watchdog

Ports:
iSystemClock  in  1  system clock, all logic on rising edge
iReset  in  1  asynchronous, active-low reset
iCMDValid  in  1  host command valid (monitor only)
iCMDReady  in  N  per-sequencer ready
oCMDReady  out  1  host ready = &iCMDReady & (state==IDLE)
iCMD_Start  in  N  per-sequencer start strobe (opcode/target match & valid)
iCMD_LastStep  in  N  per-sequencer last-step pulse
iCMD_ACG_Command  in  8*N  packed, sequencer k at [8k+7:8k]
iCMD_ACG_CommandOption  in  3*N  packed
iCMD_ACG_TargetWay  in  NumberOfWays*N  packed
iCMD_ACG_NumOfData  in  16*N  packed
iCMD_ACG_CASelect  in  N  packed
iCMD_ACG_CAData  in  40*N  packed
oACG_Command  out  8  forwarded command
oACG_CommandOption  out  3  forwarded option
oACG_TargetWay  out  NumberOfWays  forwarded target way
oACG_NumOfData  out  16  forwarded data count
oACG_CASelect  out  1  forwarded C/A select
oACG_CAData  out  40  forwarded C/A data
oGrant  out  N  one-hot current owner; 0 when idle
oBusy  out  1  high in GRANT and RELEASE
oLastStep  out  1  one-cycle pulse, registered copy of owner's last step
oTimeout  out  1  one-cycle pulse on watchdog expiry
oCollision  out  1  one-cycle pulse when a non-owner starts during GRANT

Behaviour:
- Reset (iReset=0, async) values: state IDLE; oGrant=0; RR pointer=0; counter=0; oBusy=0; oLastStep/oTimeout/oCollision=0; oCMDReady=0 until first clock after reset release.
- ACG idle value (reset and whenever not GRANT): Command=0, Option=0, TargetWay=0, NumOfData=0, CASelect=1, CAData=0.
- IDLE:
  - If any iCMD_Start bit is set, pick the first set bit searching upward from the RR pointer, wrapping N-1→0.
  - Next edge: oGrant=onehot(k), counter=0, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - ACG outputs are the registered slice of sequencer k, updated every clock. Latency is 1 clock from sequencer output to oACG_*.
  - Counter increments each clock and saturates at 2^32-1.
  - If iCMD_LastStep[k]=1: oLastStep=1 next cycle, go to RELEASE.
  - Else if TimeoutCycles≠0 and counter==TimeoutCycles-1: oTimeout=1 next cycle, go to RELEASE.
  - If LastStep and expiry coincide, LastStep wins and oTimeout stays 0.
  - Any iCMD_Start[j], j≠k, produces an oCollision pulse next cycle. It is not queued, and the grant is unchanged.
  - iCMD_LastStep from non-owners is ignored.
- RELEASE (exactly 1 cycle):
  - ACG outputs go to the idle value; oGrant=0.
  - RR pointer=(k+1) mod N.
  - Next state IDLE. Starts in this cycle are ignored; oCMDReady is already 0.
- oCMDReady:
  - Combinational from the registered state and iCMDReady.
  - Guarantees no new host command is accepted until the arbiter returns to IDLE.
- Reset asserted mid-grant:
  - Everything returns to reset values immediately, including the ACG idle value.
  - No oLastStep or oTimeout pulse is generated.
- Width rules: NumOfData and CAData pass through unchanged, with no truncation.

Test Plan:
- Single start: iCMD_Start=4'b0100 for 1 clk; sequencer 2 drives Command 8'h08, CAData 40'hEE_00_00_00_00 → oGrant=4'b0100 next clk; oACG_Command=8'h08 one clk after the driven value; iCMD_LastStep[2] → oLastStep pulse, one RELEASE cycle, oCMDReady=1 after.
- Simultaneous starts: iCMD_Start=4'b1001 with pointer 0 → grant 0. After release, pointer=1; repeat 4'b1001 → grant 3, then pointer wraps to 0.
- Watchdog: TimeoutCycles=16, grant 1, no LastStep → oTimeout pulse exactly 16 clks after grant; ACG outputs idle (CASelect=1) the clk after; state IDLE.
- Collision: owner 0 granted; iCMD_Start[1] pulse → oCollision one clk later; oGrant stays 4'b0001; oCMDReady=0 throughout.
- Reset mid-operation: assert iReset=0 while granted with Command=8'h02 → oACG_Command=0, oGrant=0, oBusy=0 without a clock edge; no oLastStep.
- LastStep/timeout tie: TimeoutCycles=8, LastStep on cycle 8 → oLastStep=1, oTimeout=0.
